// File: rtl/calc_pkg.sv
// Shared constants for the UART hex calculator: ASCII codes, opcodes,
// error codes and the parser FSM encoding.
package calc_pkg;

    localparam logic [7:0] ASC_LF    = 8'h0A;
    localparam logic [7:0] ASC_CR    = 8'h0D;
    localparam logic [7:0] ASC_ESC   = 8'h1B;
    localparam logic [7:0] ASC_SPACE = 8'h20;
    localparam logic [7:0] ASC_AMP   = 8'h26;
    localparam logic [7:0] ASC_STAR  = 8'h2A;
    localparam logic [7:0] ASC_PLUS  = 8'h2B;
    localparam logic [7:0] ASC_MINUS = 8'h2D;
    localparam logic [7:0] ASC_SLASH = 8'h2F;
    localparam logic [7:0] ASC_0     = 8'h30;
    localparam logic [7:0] ASC_9     = 8'h39;
    localparam logic [7:0] ASC_EQ    = 8'h3D;
    localparam logic [7:0] ASC_UA    = 8'h41;
    localparam logic [7:0] ASC_UF    = 8'h46;
    localparam logic [7:0] ASC_US    = 8'h53;
    localparam logic [7:0] ASC_UU    = 8'h55;
    localparam logic [7:0] ASC_CARET = 8'h5E;
    localparam logic [7:0] ASC_LA    = 8'h61;
    localparam logic [7:0] ASC_LF_HEX = 8'h66;
    localparam logic [7:0] ASC_LS    = 8'h73;
    localparam logic [7:0] ASC_LU    = 8'h75;
    localparam logic [7:0] ASC_PIPE  = 8'h7C;

    localparam logic [2:0] OP_NONE = 3'd0;
    localparam logic [2:0] OP_ADD  = 3'd1;
    localparam logic [2:0] OP_SUB  = 3'd2;
    localparam logic [2:0] OP_MUL  = 3'd3;
    localparam logic [2:0] OP_DIV  = 3'd4;
    localparam logic [2:0] OP_AND  = 3'd5;
    localparam logic [2:0] OP_OR   = 3'd6;
    localparam logic [2:0] OP_XOR  = 3'd7;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_ILLEGAL  = 2'd1;
    localparam logic [1:0] ERR_OVERFLOW = 2'd2;
    localparam logic [1:0] ERR_EMPTY    = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SRC1 = 2'd1,
        S_SRC2 = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Returns OP_NONE for any byte that is not an operator character.
    function automatic logic [2:0] op_decode(input logic [7:0] c);
        case (c)
            ASC_PLUS:  op_decode = OP_ADD;
            ASC_MINUS: op_decode = OP_SUB;
            ASC_STAR:  op_decode = OP_MUL;
            ASC_SLASH: op_decode = OP_DIV;
            ASC_AMP:   op_decode = OP_AND;
            ASC_PIPE:  op_decode = OP_OR;
            ASC_CARET: op_decode = OP_XOR;
            default:   op_decode = OP_NONE;
        endcase
    endfunction

endpackage

// File: rtl/hex_char_decode.sv
// Combinational ASCII classifier: hex digit value and sign prefix detection.
// Lowercase digits and sign prefixes are accepted only with LOWERCASE_HEX_EN.
module hex_char_decode
    import calc_pkg::*;
(
    input  logic [7:0] ch,
    output logic       is_hex,
    output logic [3:0] nib,
    output logic       is_sign,
    output logic       sign_s
);

    always_comb begin
        is_hex  = 1'b0;
        nib     = 4'h0;
        is_sign = 1'b0;
        sign_s  = 1'b0;
        if (ch >= ASC_0 && ch <= ASC_9) begin
            is_hex = 1'b1;
            nib    = ch[3:0];
        end else if (ch >= ASC_UA && ch <= ASC_UF) begin
            // 'A' is 0x41, so low nibble + 9 gives 10..15
            is_hex = 1'b1;
            nib    = ch[3:0] + 4'd9;
        end else if (ch == ASC_US || ch == ASC_UU) begin
            is_sign = 1'b1;
            sign_s  = (ch == ASC_US);
        end
`ifdef LOWERCASE_HEX_EN
        else if (ch >= ASC_LA && ch <= ASC_LF_HEX) begin
            is_hex = 1'b1;
            nib    = ch[3:0] + 4'd9;
        end else if (ch == ASC_LS || ch == ASC_LU) begin
            is_sign = 1'b1;
            sign_s  = (ch == ASC_LS);
        end
`endif
    end

endmodule

// File: rtl/hex_expr_parser.sv
// ASCII "[S|U] <hex> <op> <hex> =" parser feeding the calculator ALU.
// Optional lowercase input is enabled by defining LOWERCASE_HEX_EN.
module hex_expr_parser
    import calc_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int MAX_DIGITS = DATA_W / 4
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic              cmd_signed,
    output logic [2:0]        cmd_op,
    output logic [DATA_W-1:0] cmd_src1,
    output logic [DATA_W-1:0] cmd_src2,
    output logic              err_valid,
    output logic [1:0]        err_code
);

    localparam int CNT_W = $clog2(MAX_DIGITS + 1);

    state_t            state, state_n;
    logic [DATA_W-1:0] src1, src1_n, src2, src2_n;
    logic              sign, sign_n;
    logic [2:0]        op, op_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic              err_n;
    logic [1:0]        code_n;

    logic       is_hex, is_sign, sign_s;
    logic [3:0] nib;
    logic [2:0] op_c;
    logic       consume, at_max;

    hex_char_decode u_dec (
        .ch      (rx_data),
        .is_hex  (is_hex),
        .nib     (nib),
        .is_sign (is_sign),
        .sign_s  (sign_s)
    );

    // Handshakes: a byte transfers when rx_valid & rx_ready on a rising edge;
    // a command transfers when cmd_valid & cmd_ready, and cmd_* hold until then.
    assign rx_ready   = (state != S_DONE);
    assign cmd_valid  = (state == S_DONE);
    assign cmd_signed = sign;
    assign cmd_op     = op;
    assign cmd_src1   = src1;
    assign cmd_src2   = src2;

    assign consume = rx_valid & rx_ready;
    assign op_c    = op_decode(rx_data);
    assign at_max  = (cnt == CNT_W'(MAX_DIGITS));

    always_comb begin
        state_n = state;
        src1_n  = src1;
        src2_n  = src2;
        sign_n  = sign;
        op_n    = op;
        cnt_n   = cnt;
        err_n   = 1'b0;
        code_n  = ERR_NONE;
        if (state == S_DONE) begin
            if (cmd_ready) begin
                state_n = S_IDLE;
                src1_n  = '0;
                src2_n  = '0;
                sign_n  = 1'b0;
                cnt_n   = '0;
            end
        end else if (consume && !(rx_data == ASC_SPACE || rx_data == ASC_CR
                                  || rx_data == ASC_LF)) begin
            if (rx_data == ASC_ESC) begin
                state_n = S_IDLE;
                src1_n  = '0;
                src2_n  = '0;
                sign_n  = 1'b0;
                cnt_n   = '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (is_sign) begin
                            sign_n  = sign_s;
                            cnt_n   = '0;
                            state_n = S_SRC1;
                        end else if (is_hex) begin
                            sign_n  = 1'b0;
                            src1_n  = DATA_W'(nib);
                            cnt_n   = CNT_W'(1);
                            state_n = S_SRC1;
                        end else if (op_c != OP_NONE) begin
                            err_n  = 1'b1;
                            code_n = ERR_EMPTY;
                        end else begin
                            err_n  = 1'b1;
                            code_n = ERR_ILLEGAL;
                        end
                    end
                    S_SRC1: begin
                        if (is_hex) begin
                            if (at_max) begin
                                err_n  = 1'b1;
                                code_n = ERR_OVERFLOW;
                            end else begin
                                src1_n = {src1[DATA_W-5:0], nib};
                                cnt_n  = cnt + CNT_W'(1);
                            end
                        end else if (op_c != OP_NONE) begin
                            if (cnt == '0) begin
                                err_n  = 1'b1;
                                code_n = ERR_EMPTY;
                            end else begin
                                op_n    = op_c;
                                cnt_n   = '0;
                                state_n = S_SRC2;
                            end
                        end else begin
                            err_n  = 1'b1;
                            code_n = ERR_ILLEGAL;
                        end
                    end
                    S_SRC2: begin
                        if (is_hex) begin
                            if (at_max) begin
                                err_n  = 1'b1;
                                code_n = ERR_OVERFLOW;
                            end else begin
                                src2_n = {src2[DATA_W-5:0], nib};
                                cnt_n  = cnt + CNT_W'(1);
                            end
                        end else if (rx_data == ASC_EQ) begin
                            if (cnt == '0) begin
                                err_n  = 1'b1;
                                code_n = ERR_EMPTY;
                            end else begin
                                state_n = S_DONE;
                            end
                        end else begin
                            err_n  = 1'b1;
                            code_n = ERR_ILLEGAL;
                        end
                    end
                    default: state_n = S_IDLE;
                endcase
            end
        end
        // Any error abandons the expression entirely
        if (err_n) begin
            state_n = S_IDLE;
            src1_n  = '0;
            src2_n  = '0;
            sign_n  = 1'b0;
            cnt_n   = '0;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= S_IDLE;
            src1      <= '0;
            src2      <= '0;
            sign      <= 1'b0;
            op        <= OP_NONE;
            cnt       <= '0;
            err_valid <= 1'b0;
            err_code  <= ERR_NONE;
        end else begin
            state     <= state_n;
            src1      <= src1_n;
            src2      <= src2_n;
            sign      <= sign_n;
            op        <= op_n;
            cnt       <= cnt_n;
            err_valid <= err_n;
            if (err_n) err_code <= code_n;
        end
    end

endmodule

// File: tb/tb_hex_expr_parser.sv
// Directed bench for hex_expr_parser with command/error scoreboards.
// Honours LOWERCASE_HEX_EN for the lowercase-input step.
module tb_hex_expr_parser;

    localparam int DATA_W = 16;
    localparam int CMD_W  = 1 + 3 + 2 * DATA_W;

    logic              clk = 1'b0;
    logic              n_rst = 1'b0;
    logic [7:0]        rx_data = 8'h00;
    logic              rx_valid = 1'b0;
    logic              rx_ready;
    logic              cmd_valid;
    logic              cmd_ready = 1'b1;
    logic              cmd_signed;
    logic [2:0]        cmd_op;
    logic [DATA_W-1:0] cmd_src1;
    logic [DATA_W-1:0] cmd_src2;
    logic              err_valid;
    logic [1:0]        err_code;

    int total = 0;
    int bad   = 0;

    logic [CMD_W-1:0] exp_q[$];
    logic [1:0]       err_q[$];

    hex_expr_parser #(.DATA_W(DATA_W)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_signed (cmd_signed),
        .cmd_op     (cmd_op),
        .cmd_src1   (cmd_src1),
        .cmd_src2   (cmd_src2),
        .err_valid  (err_valid),
        .err_code   (err_code)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        int gap;
        gap = $urandom_range(0, 1);
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    task automatic push_cmd(input logic sg, input logic [2:0] op,
                            input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        exp_q.push_back({sg, op, a, b});
    endtask

    // Output monitor: compares each accepted command and each error pulse.
    always @(negedge clk) begin
        if (n_rst && cmd_valid && cmd_ready) begin
            total++;
            assert (exp_q.size() != 0) else begin
                bad++;
                $error("FAIL unexpected_cmd got=%0h exp=none",
                       {cmd_signed, cmd_op, cmd_src1, cmd_src2});
            end
            if (exp_q.size() != 0) check("cmd", 64'({cmd_signed, cmd_op, cmd_src1, cmd_src2}),
                                         64'(exp_q.pop_front()));
        end
        if (n_rst && err_valid) begin
            total++;
            assert (err_q.size() != 0) else begin
                bad++;
                $error("FAIL unexpected_err got=%0d exp=none", err_code);
            end
            if (err_q.size() != 0) check("err_code", 64'(err_code), 64'(err_q.pop_front()));
        end
    end

    initial begin
        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_rx_ready", 64'(rx_ready), 64'(1));
        check("rst_cmd_valid", 64'(cmd_valid), 64'(0));
        check("rst_outputs", 64'({cmd_signed, cmd_op, cmd_src1, cmd_src2}), 64'(0));
        check("rst_err", 64'({err_valid, err_code}), 64'(0));
        n_rst = 1'b1;
        @(posedge clk);
        #1;

        // 1: basic add, latency of one cycle after '='
        push_cmd(1'b0, 3'd1, 16'h001A, 16'h0002);
        send_str("1A+2=");
        check("t1_latency", 64'(cmd_valid), 64'(1));
        @(posedge clk);
        #1;
        check("t1_cleared", 64'({cmd_signed, cmd_src1, cmd_src2}), 64'(0));

        // 2: signed with whitespace, held while cmd_ready=0, extra bytes dropped
        cmd_ready = 1'b0;
        push_cmd(1'b1, 3'd2, 16'h00FF, 16'h0010);
        send_str("S FF - 10 =");
        for (int i = 0; i < 5; i++) begin
            check("t2_rx_ready", 64'(rx_ready), 64'(0));
            check("t2_held", 64'({cmd_valid, cmd_signed, cmd_op, cmd_src1, cmd_src2}),
                  64'({1'b1, 1'b1, 3'd2, 16'h00FF, 16'h0010}));
            send(8'h37);
        end
        cmd_ready = 1'b1;
        @(posedge clk);
        #1;
        check("t2_accept", 64'({cmd_valid, cmd_signed, cmd_src1}), 64'(0));

        // 3: digit overflow, then follow-on bytes re-parsed from idle
        err_q.push_back(2'd2);
        err_q.push_back(2'd3);
        err_q.push_back(2'd1);
        send_str("12345+1=");
        push_cmd(1'b0, 3'd3, 16'h0002, 16'h0003);
        send_str("2*3=");
        @(posedge clk);
        #1;

        // 4: empty operands and illegal char
        err_q.push_back(2'd3);
        err_q.push_back(2'd1);
        send_str("+5=");
        err_q.push_back(2'd3);
        send_str("7/=");
        err_q.push_back(2'd1);
        send_str("7G");
        @(posedge clk);
        #1;
        check("t4_err_held", 64'({err_valid, err_code}), 64'({1'b0, 2'd1}));

        // 5: ESC abort, then reset mid-expression
        push_cmd(1'b0, 3'd7, 16'h0003, 16'h0004);
        send_str("AB");
        send(8'h1B);
        send_str("3^4=");
        @(posedge clk);
        #1;
        send_str("12+");
        n_rst = 1'b0;
        #1;
        check("t5_rst_ready", 64'({rx_ready, cmd_valid}), 64'({1'b1, 1'b0}));
        check("t5_rst_outputs", 64'({cmd_signed, cmd_op, cmd_src1, cmd_src2}), 64'(0));
        check("t5_rst_err", 64'({err_valid, err_code}), 64'(0));
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        push_cmd(1'b0, 3'd5, 16'h0005, 16'h0006);
        send_str("5&6=");
        @(posedge clk);
        #1;

        // 6: lowercase input
`ifdef LOWERCASE_HEX_EN
        push_cmd(1'b0, 3'd6, 16'h000A, 16'h000B);
        send_str("a|b=");
`else
        err_q.push_back(2'd1);
        send_str("a");
        send(8'h1B);
`endif
        repeat (5) @(posedge clk);
        #1;
        check("cmd_q_empty", 64'(exp_q.size()), 64'(0));
        check("err_q_empty", 64'(err_q.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
